// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: the WB stage has priority, and LLU results wait in a FIFO.
// A scoreboard of LLU-pending destinations raises the decode stall on RAW and WAW hazards.
module rf_write_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        llu_valid,
  input  logic [4:0]  llu_reg,
  input  logic [31:0] llu_data,
  output logic        llu_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_reg,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic        id_we,
  output logic        stall,
  output logic        RegWrite,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData,
  output logic [31:0] pending
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [4:0]    fifo_reg  [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   pend_q, pend_nxt, eff_pend;
  logic          wb_live, empty, full, drain, push;
  logic [4:0]    head_reg;
  logic [31:0]   head_data;

  assign wb_live   = wb_we && (wb_reg != 5'd0);
  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign head_reg  = fifo_reg[rd_ptr];
  assign head_data = fifo_data[rd_ptr];

  // Ready depends only on registered count, so a same-cycle pop does not open a slot.
  assign llu_ready = !reset && !full;
  assign drain     = !reset && !wb_live && !empty;
  // A result for r0 is accepted but discarded.
  assign push      = llu_valid && llu_ready && (llu_reg != 5'd0);
  assign pending   = pend_q;

  always_comb begin
    RegWrite      = 1'b0;
    WriteRegister = 5'd0;
    WriteData     = 32'd0;
    if (!reset) begin
      if (wb_live) begin
        RegWrite      = 1'b1;
        WriteRegister = wb_reg;
        WriteData     = wb_data;
      end else if (drain) begin
        RegWrite      = 1'b1;
        WriteRegister = head_reg;
        WriteData     = head_data;
      end
    end
  end

  // The register being drained is covered by RegFile write-through.
  always_comb begin
    eff_pend = pend_q;
    if (drain) eff_pend[head_reg] = 1'b0;
  end

  always_comb begin
    stall = 1'b0;
    if (!reset && id_valid)
      stall = ((id_rs != 5'd0) && eff_pend[id_rs]) ||
              ((id_rt != 5'd0) && eff_pend[id_rt]) ||
              (id_we && (id_rd != 5'd0) && eff_pend[id_rd]);
  end

  // Set after clear so an issue to the register being drained stays pending.
  always_comb begin
    pend_nxt = pend_q;
    if (drain) pend_nxt[head_reg] = 1'b0;
    if (issue_valid && (issue_reg != 5'd0)) pend_nxt[issue_reg] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      pend_q <= '0;
    end else begin
      pend_q <= pend_nxt;
      if (push)  wr_ptr <= wr_ptr + AW'(1);
      if (drain) rd_ptr <= rd_ptr + AW'(1);
      case ({push, drain})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg[wr_ptr]  <= llu_reg;
      fifo_data[wr_ptr] <= llu_data;
    end
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: a queue-based reference model is checked on every cycle,
// followed by directed scenarios with literal expectations and then randomized traffic.
module tb_rf_write_arbiter;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, wb_we, llu_valid, llu_ready, issue_valid, id_valid, id_we, stall, RegWrite;
  logic [4:0]  wb_reg, llu_reg, issue_reg, id_rs, id_rt, id_rd, WriteRegister;
  logic [31:0] wb_data, llu_data, WriteData, pending;

  rf_write_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
    .llu_valid(llu_valid), .llu_reg(llu_reg), .llu_data(llu_data), .llu_ready(llu_ready),
    .issue_valid(issue_valid), .issue_reg(issue_reg),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_we(id_we),
    .stall(stall), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
    .WriteData(WriteData), .pending(pending)
  );

  int errors = 0, checks = 0;
  bit chk_en = 0;

  logic [4:0]  q_reg[$];
  logic [31:0] q_data[$];
  logic [31:0] m_pend = '0;

  logic        o_rw, o_ready, o_stall;
  logic [4:0]  o_wr;
  logic [31:0] o_wd, o_pend;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic idle_in();
    reset = 0; wb_we = 0; wb_reg = 0; wb_data = 0;
    llu_valid = 0; llu_reg = 0; llu_data = 0;
    issue_valid = 0; issue_reg = 0;
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_we = 0;
  endtask

  // One clock: check outputs at the falling edge against the model, then advance the model.
  task automatic step();
    bit          live, drn;
    logic        e_rw, e_ready, e_stall;
    logic [4:0]  e_wr;
    logic [31:0] e_wd, eff;
    @(negedge clk);
    o_rw = RegWrite; o_wr = WriteRegister; o_wd = WriteData;
    o_ready = llu_ready; o_stall = stall; o_pend = pending;

    live    = wb_we && (wb_reg != 0);
    drn     = !reset && !live && (q_reg.size() > 0);
    e_ready = !reset && (q_reg.size() < DEPTH);
    e_rw = 0; e_wr = 0; e_wd = 0;
    if (!reset && live) begin
      e_rw = 1; e_wr = wb_reg; e_wd = wb_data;
    end else if (drn) begin
      e_rw = 1; e_wr = q_reg[0]; e_wd = q_data[0];
    end
    eff = m_pend;
    if (drn) eff[q_reg[0]] = 1'b0;
    e_stall = !reset && id_valid &&
              ((id_rs != 0 && eff[id_rs]) || (id_rt != 0 && eff[id_rt]) ||
               (id_we && id_rd != 0 && eff[id_rd]));

    if (chk_en) begin
      chk("RegWrite", o_rw, e_rw);
      chk("WriteRegister", o_wr, e_wr);
      chk("WriteData", o_wd, e_wd);
      chk("llu_ready", o_ready, e_ready);
      chk("stall", o_stall, e_stall);
      chk("pending", o_pend, m_pend);
    end

    if (reset) begin
      q_reg.delete(); q_data.delete(); m_pend = '0;
    end else begin
      if (drn) begin
        m_pend[q_reg[0]] = 1'b0;
        void'(q_reg.pop_front()); void'(q_data.pop_front());
      end
      if (llu_valid && e_ready && llu_reg != 0) begin
        q_reg.push_back(llu_reg); q_data.push_back(llu_data);
      end
      if (issue_valid && issue_reg != 0) m_pend[issue_reg] = 1'b1;
      m_pend[0] = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    idle_in();
    reset = 1;
    step();            // DUT state is unknown before the first reset edge
    chk_en = 1;
    step();            // second reset cycle: checked
    idle_in();
    step();
    chk("lit_idle_rw", o_rw, 0);
    chk("lit_idle_pend", o_pend, 0);
    chk("lit_idle_ready", o_ready, 1);
    chk("lit_idle_stall", o_stall, 0);

    // Issue r5, push its result, watch it drain
    issue_valid = 1; issue_reg = 5; step(); idle_in();
    llu_valid = 1; llu_reg = 5; llu_data = 32'hDEADBEEF; step(); idle_in();
    chk("lit_pend5_set", o_pend[5], 1);
    step();
    chk("lit_drain_rw", o_rw, 1);
    chk("lit_drain_reg", o_wr, 5);
    chk("lit_drain_data", o_wd, 32'hDEADBEEF);
    step();
    chk("lit_pend5_clr", o_pend[5], 0);

    // WB wins over a waiting FIFO entry for three cycles
    llu_valid = 1; llu_reg = 7; llu_data = 32'h11; step(); idle_in();
    for (int i = 0; i < 3; i++) begin
      wb_we = 1; wb_reg = 3; wb_data = 32'h22; step();
      chk("lit_wb_reg", o_wr, 3);
      chk("lit_wb_data", o_wd, 32'h22);
    end
    idle_in(); step();
    chk("lit_late_reg", o_wr, 7);
    chk("lit_late_data", o_wd, 32'h11);

    // Fill the FIFO under WB pressure
    wb_we = 1; wb_reg = 1; wb_data = 32'h1;
    llu_valid = 1; llu_reg = 10; llu_data = 32'hA0; step();
    llu_reg = 11; llu_data = 32'hB0; step();
    llu_reg = 12; llu_data = 32'hC0; step();
    chk("lit_full_ready", o_ready, 0);
    idle_in(); step();
    chk("lit_fifo0", o_wr, 10);
    chk("lit_full_pop_ready", o_ready, 0);
    step();
    chk("lit_fifo1", o_wr, 11);
    chk("lit_ready_back", o_ready, 1);
    step();
    chk("lit_no_third", o_rw, 0);

    // Hazards against a pending r9
    issue_valid = 1; issue_reg = 9; step(); idle_in();
    wb_we = 1; wb_reg = 1; llu_valid = 1; llu_reg = 9; llu_data = 32'h99; step();
    llu_valid = 0; id_valid = 1; id_rs = 9; step();
    chk("lit_raw_stall", o_stall, 1);
    id_rs = 0; id_we = 1; id_rd = 9; step();
    chk("lit_waw_stall", o_stall, 1);
    idle_in(); id_valid = 1; id_rs = 9; step();
    chk("lit_drain9_reg", o_wr, 9);
    chk("lit_drain9_stall", o_stall, 0);
    idle_in(); id_valid = 1; id_rs = 0; step();
    chk("lit_r0_stall", o_stall, 0);

    // Reset with a full FIFO and a pending r4
    idle_in(); issue_valid = 1; issue_reg = 4; wb_we = 1; wb_reg = 1;
    llu_valid = 1; llu_reg = 4; llu_data = 32'h44; step();
    issue_valid = 0; llu_reg = 6; llu_data = 32'h66; step();
    idle_in(); reset = 1; step();
    chk("lit_rst_rw", o_rw, 0);
    idle_in(); step();
    chk("lit_post_rst_rw", o_rw, 0);
    chk("lit_post_rst_pend", o_pend, 0);
    chk("lit_post_rst_ready", o_ready, 1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 199) == 0);
      wb_we       = ($urandom_range(0, 99) < 45);
      wb_reg      = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      wb_data     = $urandom;
      llu_valid   = ($urandom_range(0, 99) < 40);
      llu_reg     = 5'($urandom_range(0, 7));
      llu_data    = $urandom;
      issue_valid = ($urandom_range(0, 99) < 30);
      issue_reg   = 5'($urandom_range(0, 7));
      id_valid    = ($urandom_range(0, 99) < 70);
      id_rs       = 5'($urandom_range(0, 7));
      id_rt       = 5'($urandom_range(0, 7));
      id_rd       = 5'($urandom_range(0, 7));
      id_we       = $urandom_range(0, 1) == 1;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
